// File: rtl/cms_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the
// count-min sketch counter stage.
// Optional feature macro: CMS_QUERY_EN (adds read-only query ops).
package cms_pkg;

  // Default counter width; the top level may override it.
  localparam int CNT_W  = 16;

  // Row depths and the address widths that cover them.
  localparam int DEPTH1 = 2140;
  localparam int DEPTH2 = 1070;
  localparam int DEPTH3 = 535;
  localparam int AW1    = 12;
  localparam int AW2    = 11;
  localparam int AW3    = 10;
  localparam int NROWS  = 3;

  // INIT sweeps the rows to zero, RUN accepts traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } cms_state_t;

  // Depth of a row given its index (0 = row 1).
  function automatic int row_depth(input int row);
    case (row)
      0:       return DEPTH1;
      1:       return DEPTH2;
      default: return DEPTH3;
    endcase
  endfunction

  // Address width of a row given its index (0 = row 1).
  function automatic int row_aw(input int row);
    case (row)
      0:       return AW1;
      1:       return AW2;
      default: return AW3;
    endcase
  endfunction

  // Increment that sticks at max_v instead of wrapping. Operands are
  // carried at 32 bits so any counter width up to 32 can reuse it.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] max_v);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

  // Minimum of three values.
  function automatic logic [31:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/cms_row_ram.sv
// One count-min sketch counter row: synchronous read-first memory with a
// registered read, a single write port shared by the zeroing sweep and the
// update path, and a one-deep forward of the last update so that an op
// whose read raced the previous write still sees the fresh value.
module cms_row_ram #(
  parameter int DEPTH = 2140,
  parameter int AW    = 12,
  parameter int W     = 16
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          upd_en,
  input  logic [W-1:0]  upd_data,
  input  logic          init_en,
  input  logic [AW-1:0] init_addr,
  output logic [W-1:0]  cur_data
);

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  rd_data_reg;
  logic [AW-1:0] s1_addr_reg;
  logic          fwd_valid_reg;
  logic [AW-1:0] fwd_addr_reg;
  logic [W-1:0]  fwd_data_reg;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  // Write-port mux: the zeroing sweep and the update path never overlap,
  // the sweep is given priority anyway.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s1_addr_reg;
    wr_data = upd_data;
    if (init_en) begin
      wr_en   = 1'b1;
      wr_addr = init_addr;
      wr_data = '0;
    end else if (upd_en) begin
      wr_en   = 1'b1;
    end
  end

  // Memory write port.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read (read-first) and the address of the op now in S1.
  always_ff @(posedge sys_clk) begin
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
      s1_addr_reg <= rd_addr;
    end
  end

  // Remember whether an update was written on the last edge.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_reg <= 1'b0;
    end else begin
      fwd_valid_reg <= upd_en && !init_en;
    end
  end

  // Capture address and value of the last update for forwarding.
  always_ff @(posedge sys_clk) begin
    if (upd_en) begin
      fwd_addr_reg <= s1_addr_reg;
      fwd_data_reg <= upd_data;
    end
  end

  // The S1 op read on the same edge the previous update was written, so a
  // matching address must take the forwarded value rather than stale RAM data.
  assign cur_data = (fwd_valid_reg && (fwd_addr_reg == s1_addr_reg)) ?
                    fwd_data_reg : rd_data_reg;

endmodule

// File: rtl/cms_counter_update.sv
// Count-min sketch counter stage. Takes the three hash addresses, does a
// saturating read-increment-write on each row with a fixed two-cycle
// latency, and reports the minimum of the three updated counters.
// Zeroes all rows after reset and on Clear_req.
// Optional feature macro: CMS_QUERY_EN adds Op_query, which returns the
// minimum of the current counters without writing.
module cms_counter_update #(
  parameter int CNT_W = cms_pkg::CNT_W
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic [cms_pkg::AW1-1:0] Hash_add1,
  input  logic [cms_pkg::AW2-1:0] Hash_add2,
  input  logic [cms_pkg::AW3-1:0] Hash_add3,
  input  logic                    Hash_valid,
`ifdef CMS_QUERY_EN
  input  logic                    Op_query,
`endif
  input  logic                    Clear_req,
  output logic                    Init_done,
  output logic [CNT_W-1:0]        Est_value,
  output logic                    Est_valid,
  output logic [15:0]             Drop_cnt
);

  import cms_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cms_state_t       state_reg;
  logic [AW1-1:0]   init_addr_reg;
  logic             init_done_reg;
  logic             s1_valid_reg;
  logic             s1_query_reg;
  logic [CNT_W-1:0] est_value_reg;
  logic             est_valid_reg;
  logic [15:0]      drop_cnt_reg;

  logic             op_query;
  logic             in_range;
  logic             accept;
  logic             in_init;
  logic             s1_update;
  logic [CNT_W-1:0] old_val [NROWS];
  logic [CNT_W-1:0] new_val [NROWS];
  logic [CNT_W-1:0] est_next;

`ifdef CMS_QUERY_EN
  assign op_query = Op_query;
`else
  assign op_query = 1'b0;
`endif

  assign in_range  = (Hash_add1 < AW1'(DEPTH1)) &&
                     (Hash_add2 < AW2'(DEPTH2)) &&
                     (Hash_add3 < AW3'(DEPTH3));
  assign accept    = Hash_valid && (state_reg == RUN) && !Clear_req && in_range;
  assign in_init   = (state_reg == INIT);
  assign s1_update = s1_valid_reg && !s1_query_reg;

  // Control FSM: one zeroing write per cycle in INIT, then RUN until cleared.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      init_addr_reg <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          if (Clear_req) begin
            init_addr_reg <= '0;
          end else if (init_addr_reg == AW1'(DEPTH1 - 1)) begin
            state_reg     <= RUN;
            init_done_reg <= 1'b1;
            init_addr_reg <= '0;
          end else begin
            init_addr_reg <= init_addr_reg + AW1'(1);
          end
        end
        RUN: begin
          if (Clear_req) begin
            state_reg     <= INIT;
            init_done_reg <= 1'b0;
            init_addr_reg <= '0;
          end
        end
      endcase
    end
  end

  // S1 stage bookkeeping: which cycle holds a live op and its kind.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_query_reg <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      s1_query_reg <= accept && op_query;
    end
  end

  // Three counter rows, each with its own address width and depth.
  for (genvar gi = 0; gi < NROWS; gi++) begin : g_row
    localparam int RD  = row_depth(gi);
    localparam int RAW = row_aw(gi);

    logic [RAW-1:0] row_addr;
    logic           init_en;

    if (gi == 0) begin : g_a1
      assign row_addr = Hash_add1;
    end else if (gi == 1) begin : g_a2
      assign row_addr = Hash_add2;
    end else begin : g_a3
      assign row_addr = Hash_add3;
    end

    // Shorter rows simply skip the tail of the sweep.
    assign init_en     = in_init && (init_addr_reg < AW1'(RD));
    assign new_val[gi] = CNT_W'(sat_inc(32'(old_val[gi]), 32'(CNT_MAX)));

    cms_row_ram #(
      .DEPTH (RD),
      .AW    (RAW),
      .W     (CNT_W)
    ) u_ram (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .rd_en     (accept),
      .rd_addr   (row_addr),
      .upd_en    (s1_update),
      .upd_data  (new_val[gi]),
      .init_en   (init_en),
      .init_addr (init_addr_reg[RAW-1:0]),
      .cur_data  (old_val[gi])
    );
  end

  // Estimate: updates report the new minimum, queries the current one.
  always_comb begin
    est_next = CNT_W'(min3(32'(new_val[0]), 32'(new_val[1]), 32'(new_val[2])));
    if (s1_query_reg) begin
      est_next = CNT_W'(min3(32'(old_val[0]), 32'(old_val[1]), 32'(old_val[2])));
    end
  end

  // Output register: pulse valid per completed op, hold value otherwise.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      est_valid_reg <= 1'b0;
      est_value_reg <= '0;
    end else begin
      est_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        est_value_reg <= est_next;
      end
    end
  end

  // Count rejected Hash_valid cycles, sticking at all-ones.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
    end else if (Hash_valid && !accept && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign Init_done = init_done_reg;
  assign Est_value = est_value_reg;
  assign Est_valid = est_valid_reg;
  assign Drop_cnt  = drop_cnt_reg;

endmodule
